// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Purpose  : Shared definitions for the core sequencing controller. This
//            package holds the controller state encoding, the default fetch
//            timeout, the reset value of the instruction latch, and a small
//            state-class helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

  // Controller state encoding. The explicit width is shared by all users.
  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_FETCH_REQ  = 3'd1,
    ST_FETCH_WAIT = 3'd2,
    ST_EXEC       = 3'd3,
    ST_HALT       = 3'd4,
    ST_ERROR      = 3'd5
  } state_t;

  // Maximum number of cycles spent in FETCH_REQ plus FETCH_WAIT.
  localparam int          c_TIMEOUT_DEFAULT = 255;

  // Instruction latch reset value: addi x0, x0, 0 (the canonical nop).
  localparam logic [31:0] c_NOP             = 32'h0000_0013;

  // True for the two states that count against the fetch timeout.
  function automatic logic is_fetch_state(input state_t s);
    return (s == ST_FETCH_REQ) || (s == ST_FETCH_WAIT);
  endfunction

  // True for the states in which the core does useful work (cycle counter).
  function automatic logic is_active_state(input state_t s);
    return (s == ST_FETCH_REQ) || (s == ST_FETCH_WAIT) || (s == ST_EXEC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : core_seq_ctrl_if
// Purpose  : Instruction-memory request/response bus between the sequencing
//            controller (master) and instruction memory (slave).
// Signals  : imem_req_valid  master->slave  fetch request valid
//            imem_req_ready  slave->master  memory accepts request
//            imem_addr[31:0] master->slave  fetch address
//            imem_rsp_valid  slave->master  instruction data valid
//            imem_rsp_data   slave->master  fetched instruction word
//            imem_rsp_ready  master->slave  controller accepts response
// Revision : 1.0 - initial release
// ============================================================================
interface core_seq_ctrl_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_ready;

  modport master (
    output imem_req_valid,
    output imem_addr,
    output imem_rsp_ready,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    input  imem_rsp_ready,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface
`default_nettype wire

// File: rtl/perf_counter.sv
`default_nettype none
// ============================================================================
// Module   : perf_counter
// Purpose  : Free-running event counter that wraps modulo 2^CNT_W.
// Ports    : clk         clock
//            reset       asynchronous active-high reset (count -> 0)
//            i_en        count enable, one increment per enabled cycle
//            o_cnt       current count
// Revision : 1.0 - initial release
// ============================================================================
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_en,
  output logic      [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Overflow simply rolls over to zero; no saturation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/core_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : core_seq_ctrl
// Purpose  : Multi-cycle fetch/execute sequencer for a simple core. It issues
//            an instruction fetch at pc and latches the returned word into ist.
//            It then grants one execute cycle (rf write and PC load). It stops
//            on ebreak (HALT) or on a fetch that exceeds TIMEOUT cycles
//            (ERROR). It also keeps cycle and retired-instruction counters.
// Ports    : clk             clock
//            reset           asynchronous active-high reset
//            pc[31:0]        current PC from the datapath
//            imem            instruction-memory bus (master side)
//            ist[31:0]       latched instruction to decode
//            is_ebreak       decode flag: ist is ebreak
//            exec_en         rf write enable gate (EXEC only)
//            pc_wen          PC register load enable (EXEC only)
//            halted          sticky: ebreak executed
//            fetch_err       sticky: fetch timed out
//            cycle_cnt       active cycles (not RESET/HALT/ERROR)
//            instret_cnt     EXEC cycles, ebreak included
// Revision : 1.0 - initial release
// ============================================================================
module core_seq_ctrl
  import core_pkg::*;
#(
  parameter int TIMEOUT = c_TIMEOUT_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic [31:0]      pc,
  core_seq_ctrl_if.master       imem,
  output logic      [31:0]      ist,
  input  wire logic             is_ebreak,
  output logic                  exec_en,
  output logic                  pc_wen,
  output logic                  halted,
  output logic                  fetch_err,
  output logic      [CNT_W-1:0] cycle_cnt,
  output logic      [CNT_W-1:0] instret_cnt
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_wait;
  logic [31:0] w_wait_inc;
  logic        w_timeout;
  logic [31:0] r_ist;

  logic        w_req_valid;
  logic        w_rsp_ready;
  logic        w_exec;
  logic        w_latch;

  // ---------------------------------------------------------------------------
  // Fetch wait counter. r_wait holds the number of fetch cycles already spent
  // on the current instruction. w_timeout flags the cycle that would reach
  // TIMEOUT.
  // ---------------------------------------------------------------------------
  assign w_wait_inc = r_wait + 32'd1;
  assign w_timeout  = (w_wait_inc >= 32'(TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait <= 32'd0;
    end else if ((r_state == ST_RESET) || (r_state == ST_EXEC)) begin
      // Both states are left only toward a fresh fetch (or HALT), so clearing
      // here gives every instruction its own full timeout budget.
      r_wait <= 32'd0;
    end else if (is_fetch_state(r_state)) begin
      r_wait <= w_wait_inc;
    end
  end

  // ---------------------------------------------------------------------------
  // State register. An asynchronous reset forces RESET immediately and
  // abandons any in-flight fetch.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_req_valid = 1'b0;
    w_rsp_ready = 1'b0;
    w_exec      = 1'b0;
    w_latch     = 1'b0;
    unique case (r_state)
      ST_RESET: begin
        w_state_nxt = ST_FETCH_REQ;
      end
      ST_FETCH_REQ: begin
        w_req_valid = 1'b1;
        if (w_timeout) begin
          w_state_nxt = ST_ERROR;
        end else if (imem.imem_req_ready) begin
          w_state_nxt = ST_FETCH_WAIT;
        end
      end
      ST_FETCH_WAIT: begin
        w_rsp_ready = 1'b1;
        // If a response arrives in the timeout cycle, the response wins.
        if (imem.imem_rsp_valid) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_EXEC;
        end else if (w_timeout) begin
          w_state_nxt = ST_ERROR;
        end
      end
      ST_EXEC: begin
        if (is_ebreak) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_exec      = 1'b1;
          w_state_nxt = ST_FETCH_REQ;
        end
      end
      ST_HALT, ST_ERROR: begin
        w_state_nxt = r_state;
      end
      default: begin
        w_state_nxt = ST_ERROR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Instruction latch. The latch is written only on an accepted response, so
  // responses outside FETCH_WAIT leave it untouched.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ist <= c_NOP;
    end else if (w_latch) begin
      r_ist <= imem.imem_rsp_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem.imem_req_valid = w_req_valid;
  assign imem.imem_addr      = w_req_valid ? pc : 32'd0;
  assign imem.imem_rsp_ready = w_rsp_ready;

  assign ist       = r_ist;
  assign exec_en   = w_exec;
  assign pc_wen    = w_exec;
  assign halted    = (r_state == ST_HALT);
  assign fetch_err = (r_state == ST_ERROR);

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  perf_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .i_en  (is_active_state(r_state)),
    .o_cnt (cycle_cnt)
  );

  perf_counter #(
    .CNT_W (CNT_W)
  ) u_instret_cnt (
    .clk   (clk),
    .reset (reset),
    .i_en  (r_state == ST_EXEC),
    .o_cnt (instret_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_core_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_seq_ctrl
// Purpose  : Self-checking bench for core_seq_ctrl. It runs directed scenarios
//            and then randomized bus traffic. A phase-level behavioural model
//            predicts every output on every cycle.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_seq_ctrl;

  localparam int          TO       = 8;
  localparam int          CW       = 8;
  localparam logic [31:0] c_NOP    = 32'h0000_0013;
  localparam logic [31:0] c_ADDI   = 32'h0010_0093;
  localparam logic [31:0] c_EBREAK = 32'h0010_0073;

  // Model phases (bench-local numbering)
  localparam int P_RST = 0, P_REQ = 1, P_WAIT = 2, P_EXEC = 3, P_HALT = 4, P_ERR = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   pc;
  logic [31:0]   ist;
  logic          is_ebreak;
  logic          exec_en;
  logic          pc_wen;
  logic          halted;
  logic          fetch_err;
  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] instret_cnt;

  int total = 0;
  int bad   = 0;

  core_seq_ctrl_if bus ();

  core_seq_ctrl #(
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .imem        (bus.master),
    .ist         (ist),
    .is_ebreak   (is_ebreak),
    .exec_en     (exec_en),
    .pc_wen      (pc_wen),
    .halted      (halted),
    .fetch_err   (fetch_err),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  // The datapath decoder: flags ebreak for whatever word is latched.
  assign is_ebreak = (ist == c_EBREAK);

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. The model tracks which phase of the instruction life
  // cycle the core is in, how many fetch cycles the current instruction has
  // used, the last accepted word, and the two counts. At each falling edge it
  // compares the DUT against the expected outputs, then advances to the next
  // cycle.
  // ---------------------------------------------------------------------------
  int            ph           = P_RST;
  int            fetch_cycles = 0;
  logic [31:0]   m_ist        = c_NOP;
  logic [CW-1:0] m_cyc        = '0;
  logic [CW-1:0] m_ins        = '0;

  always @(negedge clk) begin
    if (reset) begin
      ph           = P_RST;
      fetch_cycles = 0;
      m_ist        = c_NOP;
      m_cyc        = '0;
      m_ins        = '0;
    end
    chk("req_valid",   64'(bus.imem_req_valid), 64'(ph == P_REQ));
    chk("imem_addr",   64'(bus.imem_addr),      64'((ph == P_REQ) ? pc : 32'h0));
    chk("rsp_ready",   64'(bus.imem_rsp_ready), 64'(ph == P_WAIT));
    chk("exec_en",     64'(exec_en),            64'((ph == P_EXEC) && !is_ebreak));
    chk("pc_wen",      64'(pc_wen),             64'((ph == P_EXEC) && !is_ebreak));
    chk("halted",      64'(halted),             64'(ph == P_HALT));
    chk("fetch_err",   64'(fetch_err),          64'(ph == P_ERR));
    chk("ist",         64'(ist),                64'(m_ist));
    chk("cycle_cnt",   64'(cycle_cnt),          64'(m_cyc));
    chk("instret_cnt", 64'(instret_cnt),        64'(m_ins));
    if (!reset) begin
      if (ph == P_REQ || ph == P_WAIT || ph == P_EXEC) m_cyc++;
      case (ph)
        P_RST: begin
          ph           = P_REQ;
          fetch_cycles = 0;
        end
        P_REQ: begin
          fetch_cycles++;
          if (fetch_cycles >= TO)         ph = P_ERR;
          else if (bus.imem_req_ready)    ph = P_WAIT;
        end
        P_WAIT: begin
          fetch_cycles++;
          if (bus.imem_rsp_valid) begin
            m_ist = bus.imem_rsp_data;
            ph    = P_EXEC;
          end else if (fetch_cycles >= TO) begin
            ph = P_ERR;
          end
        end
        P_EXEC: begin
          m_ins++;
          if (is_ebreak) ph = P_HALT;
          else begin
            ph           = P_REQ;
            fetch_cycles = 0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus. Inputs change 1 time unit after a rising edge. Literal checks
  // sample 4 time units after the edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Returns 1 time unit into the first cycle after reset release (RESET state).
  task automatic apply_reset();
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    pc                 = 32'h0000_1000;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;

    // Reset values
    tick(); tick(); settle();
    chk("rst_ist",       64'(ist),                64'(c_NOP));
    chk("rst_cycle_cnt", 64'(cycle_cnt),          64'(0));
    chk("rst_req_valid", 64'(bus.imem_req_valid), 64'(0));

    // Best-case addi: release -> REQ (accepted) -> WAIT (rsp) -> EXEC on cycle 4
    tick(); reset = 1'b0; bus.imem_req_ready = 1'b1;            // cycle 1
    settle(); chk("c1_req_valid", 64'(bus.imem_req_valid), 64'(0));
    tick(); settle();                                           // cycle 2
    chk("c2_req_valid", 64'(bus.imem_req_valid), 64'(1));
    chk("c2_addr",      64'(bus.imem_addr),      64'(32'h0000_1000));
    tick(); bus.imem_req_ready = 1'b0;                          // cycle 3
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = c_ADDI;
    settle(); chk("c3_rsp_ready", 64'(bus.imem_rsp_ready), 64'(1));
    tick(); bus.imem_rsp_valid = 1'b0; settle();                // cycle 4
    chk("c4_exec_en", 64'(exec_en), 64'(1));
    chk("c4_pc_wen",  64'(pc_wen),  64'(1));
    chk("c4_ist",     64'(ist),     64'(c_ADDI));

    // Ready held low for 5 cycles in FETCH_REQ
    tick(); pc = 32'h0000_1004; settle();                       // cycle 5
    chk("c5_instret", 64'(instret_cnt), 64'(1));
    chk("c5_cycles",  64'(cycle_cnt),   64'(3));
    chk("stall_valid0", 64'(bus.imem_req_valid), 64'(1));
    chk("stall_addr0",  64'(bus.imem_addr),      64'(32'h0000_1004));
    for (int i = 1; i < 5; i++) begin
      tick(); settle();
      chk("stall_valid", 64'(bus.imem_req_valid), 64'(1));
      chk("stall_addr",  64'(bus.imem_addr),      64'(32'h0000_1004));
    end
    tick(); bus.imem_req_ready = 1'b1; settle();
    chk("accept_valid", 64'(bus.imem_req_valid), 64'(1));

    // ebreak: halt, then no further requests even with ready high
    tick(); bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = c_EBREAK;
    settle(); chk("wait_rsp_ready", 64'(bus.imem_rsp_ready), 64'(1));
    tick(); bus.imem_rsp_valid = 1'b0; settle();
    chk("ebreak_exec_en", 64'(exec_en), 64'(0));
    chk("ebreak_pc_wen",  64'(pc_wen),  64'(0));
    tick(); bus.imem_req_ready = 1'b1; settle();
    chk("halted", 64'(halted), 64'(1));
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      chk("halt_no_req", 64'(bus.imem_req_valid), 64'(0));
    end

    // Timeout: no acceptance for TO fetch cycles
    apply_reset(); bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
    repeat (8) tick();
    settle(); chk("to_not_yet", 64'(fetch_err), 64'(0));
    tick(); settle();
    chk("to_fetch_err", 64'(fetch_err), 64'(1));
    chk("to_cycles",    64'(cycle_cnt), 64'(8));
    repeat (3) tick();
    settle(); chk("to_cycles_frozen", 64'(cycle_cnt), 64'(8));
    chk("to_no_req", 64'(bus.imem_req_valid), 64'(0));

    // Reset in FETCH_WAIT with a response pulsed during reset
    apply_reset(); bus.imem_req_ready = 1'b1;                   // cycle 1
    tick();                                                     // cycle 2
    tick(); bus.imem_req_ready = 1'b0; settle();                // cycle 3
    chk("rw_rsp_ready", 64'(bus.imem_rsp_ready), 64'(1));
    tick(); reset = 1'b1;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hCAFE_F00D;
    settle();
    chk("rw_ist_in_reset", 64'(ist),                64'(c_NOP));
    chk("rw_ready_off",    64'(bus.imem_rsp_ready), 64'(0));
    tick(); reset = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_req_ready = 1'b1;
    settle(); chk("rw_ist_after", 64'(ist), 64'(c_NOP));
    tick(); settle();
    chk("rw_restart", 64'(bus.imem_req_valid), 64'(1));

    // Spurious responses in EXEC and FETCH_REQ are ignored
    tick(); bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = c_ADDI;
    tick(); bus.imem_rsp_data = 32'hDEAD_BEEF; settle();        // EXEC
    chk("sp_exec_ist", 64'(ist), 64'(c_ADDI));
    tick(); settle();                                           // FETCH_REQ
    chk("sp_req_ist",       64'(ist),                64'(c_ADDI));
    chk("sp_req_rsp_ready", 64'(bus.imem_rsp_ready), 64'(0));
    tick(); bus.imem_rsp_valid = 1'b0;

    // Full-speed run long enough to wrap the cycle counter
    apply_reset();
    bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = c_ADDI;
    repeat (271) tick();
    settle();
    chk("wrap_cycles",  64'(cycle_cnt),   64'(14));
    chk("wrap_instret", 64'(instret_cnt), 64'(90));

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (reset) reset = 1'b0;
      else if ((halted || fetch_err) ? ($urandom_range(3) == 0) : ($urandom_range(299) == 0))
        reset = 1'b1;
      bus.imem_req_ready = ($urandom_range(2) != 0);
      bus.imem_rsp_valid = ($urandom_range(1) == 0);
      bus.imem_rsp_data  = ($urandom_range(29) == 0) ? c_EBREAK : $urandom;
      pc                 = $urandom;
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_seq_ctrl.md
CORE_SEQ_CTRL -- requirements
Module: core_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles spent in FETCH_REQ+FETCH_WAIT before error.
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of performance counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port pc  input  32  current PC from datapath PC register.
REQ-006 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-008 SHALL have port imem_addr  output  32  fetch address, equal to pc while imem_req_valid=1.
REQ-009 SHALL have port imem_rsp_valid  input  1  instruction data valid.
REQ-010 SHALL have port imem_rsp_data  input  32  fetched instruction word.
REQ-011 SHALL have port imem_rsp_ready  output  1  controller accepts response.
REQ-012 SHALL have port ist  output  32  latched instruction driven to datapath decode.
REQ-013 SHALL have port is_ebreak  input  1  decode flag, instruction on ist is ebreak.
REQ-014 SHALL have port exec_en  output  1  gates rf write enable for one cycle.
REQ-015 SHALL have port pc_wen  output  1  PC register load enable.
REQ-016 SHALL have ports halted, fetch_err  output  1 each  sticky terminal status.
REQ-017 SHALL have ports cycle_cnt, instret_cnt  output  CNT_W each  performance counters.

Function
REQ-018 SHALL implement states RESET, FETCH_REQ, FETCH_WAIT, EXEC, HALT, ERROR.
REQ-019 RESET SHALL last exactly one cycle after reset deassertion, then go to FETCH_REQ.
REQ-020 FETCH_REQ SHALL assert imem_req_valid; on imem_req_valid&&imem_req_ready SHALL go to FETCH_WAIT next cycle; imem_req_valid SHALL stay high until accepted.
REQ-021 FETCH_WAIT SHALL assert imem_rsp_ready; on imem_rsp_valid SHALL latch imem_rsp_data into ist and go to EXEC.
REQ-022 imem_rsp_valid outside FETCH_WAIT SHALL be ignored (imem_rsp_ready=0, ist unchanged).
REQ-023 EXEC SHALL last exactly one cycle; if is_ebreak=0: exec_en=1, pc_wen=1, next FETCH_REQ; if is_ebreak=1: exec_en=0, pc_wen=0, next HALT.
REQ-024 exec_en and pc_wen SHALL be 0 in every state other than EXEC.
REQ-025 Best-case throughput SHALL be one instruction per 3 cycles (FETCH_REQ, FETCH_WAIT, EXEC) with ready and response each granted in one cycle.
REQ-026 A wait counter SHALL clear on entry to FETCH_REQ from EXEC/RESET, increment each cycle in FETCH_REQ/FETCH_WAIT; reaching TIMEOUT without completed fetch SHALL enter ERROR.
REQ-027 HALT and ERROR SHALL be absorbing until reset; halted=1 in HALT, fetch_err=1 in ERROR; no requests issued.
REQ-028 cycle_cnt SHALL increment every cycle not in RESET/HALT/ERROR; instret_cnt SHALL increment on each EXEC cycle including ebreak; both wrap modulo 2^CNT_W.
REQ-029 Simultaneous timeout and imem_rsp_valid in FETCH_WAIT SHALL take the response (EXEC wins).

Reset
REQ-030 On reset assertion, state SHALL become RESET immediately, regardless of in-flight fetch.
REQ-031 Reset values SHALL be: all outputs 0, ist=32'h00000013 (nop), counters 0, wait counter 0.
REQ-032 A response arriving during or after reset for a pre-reset request SHALL be dropped.

Structure
REQ-033 State enum encoding and default TIMEOUT SHALL live in shared package core_pkg.
REQ-034 The two counters SHALL use one sub-module perf_counter (enable, wrap, CNT_W parameter), instantiated twice.

Verification
REQ-035 Reset release, ready=1, rsp 1 cycle later with addi word 0x00100093 -> exec_en and pc_wen high on cycle 4, instret_cnt=1.
REQ-036 imem_req_ready held low 5 cycles -> imem_req_valid high all 5 cycles with imem_addr=pc constant, then FETCH_WAIT.
REQ-037 Response 0x00100073 with is_ebreak=1 -> exec_en=0, pc_wen=0, halted=1 next cycle, no further imem_req_valid.
REQ-038 TIMEOUT=8, no response -> fetch_err=1 after 8 fetch cycles; cycle_cnt frozen.
REQ-039 Reset asserted in FETCH_WAIT, rsp_valid pulsed during reset -> ist=0x00000013, state RESET, restart fetch.
REQ-040 Spurious rsp_valid during EXEC -> ignored, ist unchanged.
